sa_edge_feeder: RTL and testbench
=================================

Name: sa_edge_feeder

Overview:
- Transmit side of the systolic-array operand interface. Accepts one operand vector of SYS_ARRAY_SIZE elements per cycle from the operand fetch path.
- Skews the vector across array lanes: lane i is delayed i extra cycles.
- Drives the per-lane `matrix_data_t` {data, last} streams into the array edge, with `last` tagging the final K-step.
- One instance feeds the A (row) edge and one feeds the B (column) edge. Both are started by `ctrl_t.compute_req`.

Parameters:
- N, SYS_ARRAY_SIZE (2): number of lanes, equal to the array edge length.
- DW, DATA_WIDTH (8): element width.
- KW, 8: width of the K-length field and the K counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse from `compute_req`; sampled only in IDLE.
- k_len_i  in  KW  number of vectors K in this job; sampled with start_i.
- vec_valid_i  in  1  operand vector valid.
- vec_ready_o  out  1  feeder can accept a vector.
- vec_data_i  in  N*DW  operand vector; element i is bits [i*DW +: DW].
- lane_data_o  out  N*(DW+1)  per-lane `matrix_data_t`; lane i is bits [i*(DW+1) +: DW+1], data in MSBs, last in LSB.
- lane_valid_o  out  N  per-lane valid.
- busy_o  out  1  high in FEED and FLUSH.
- done_o  out  1  one-cycle pulse when the job has fully left the feeder.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0: vec_ready_o, lane_valid_o, lane_data_o, busy_o, done_o.
  - Skew pipeline cleared, K counter 0, state IDLE.
  - Reset mid-job aborts the job. No done_o is produced.
- State machine: IDLE, FEED, FLUSH.
- IDLE:
  - vec_ready_o=0.
  - On start_i with k_len_i>0: latch K, clear counter, go to FEED next cycle.
  - On start_i with k_len_i=0: stay IDLE and assert done_o the following cycle. No lane_valid is produced.
- FEED:
  - vec_ready_o=1 combinationally.
  - A vector is accepted in any cycle where vec_valid_i and vec_ready_o are both high; the counter increments.
  - The vector carrying count==K-1 is tagged last=1. After accepting it, go to FLUSH; vec_ready_o drops the next cycle.
- Skew:
  - A vector accepted in cycle t appears on lane i in cycle t+1+i, with lane_valid_o[i]=1.
  - Lane i has an i-stage delay line feeding a registered output stage.
- Bubbles:
  - A FEED cycle with no acceptance inserts a slot with valid=0, data=0, last=0. The slot is skewed the same way on every lane.
  - Any lane slot not carrying data outputs data=0 and last=0; the array relies on zero padding.
- No back-pressure from the array: lane outputs advance every cycle.
- FLUSH:
  - Lasts exactly N cycles, t+1 through t+N, where t is the acceptance cycle of the last vector.
  - done_o=1 in cycle t+N, the same cycle lane N-1 presents its last element.
  - Return to IDLE in cycle t+N+1.
- busy_o = (state != IDLE).
- start_i outside IDLE is ignored and does not change K.
- Counter:
  - Width KW; maximum K is 2^KW-1.
  - Comparison is against K-1, so the counter never wraps inside a job.
- Back-to-back jobs: the earliest next start_i is accepted in the first IDLE cycle (t+N+1).

Test Plan:
1. Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, then assert rst_n=0 asynchronously mid-cycle -> outputs clear immediately.
2. N=2, K=3, vectors {0x01,0x02}, {0x03,0x04}, {0x05,0x06} accepted in cycles 1, 2, 3:
   - lane0 = 0x01, 0x03, 0x05 in cycles 2–4, last only on 0x05.
   - lane1 = 0x02, 0x04, 0x06 in cycles 3–5, last only on 0x06.
   - done_o in cycle 5; busy_o low from cycle 6.
3. Bubble: same job with vec_valid_i=0 in cycle 2 -> lane0 slot in cycle 3 and lane1 slot in cycle 4 are valid=0, data=0. Remaining data shifts one cycle later; done_o in cycle 6.
4. K=0: start_i in cycle 0 -> done_o in cycle 1, no lane_valid_o, busy_o stays 0.
5. start_i pulsed during FEED with k_len_i=7 -> ignored; the original K=3 job completes unchanged.
6. K=255 with continuous vectors -> exactly 255 valid slots per lane, last only on slot 255, done_o 2 cycles after the final acceptance.

Source files
------------

// File: rtl/sa_edge_feeder.sv
// Transmit side of the systolic-array operand edge: accepts one N-element vector per
// cycle, tags the final K-step with last, and skews lane i by i extra cycles.
`timescale 1ns/1ps
module sa_edge_feeder #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int KW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [KW-1:0]       k_len_i,
  input  logic                vec_valid_i,
  output logic                vec_ready_o,
  input  logic [N*DW-1:0]     vec_data_i,
  output logic [N*(DW+1)-1:0] lane_data_o,
  output logic [N-1:0]        lane_valid_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(N - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
  } slot_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k_len;
  logic [KW-1:0] count;
  logic [FW-1:0] flush_cnt;
  logic          zero_done;
  logic          accept;
  logic          is_last;
  logic          start_job;
  slot_t         in_slot [N];

  assign accept    = (state == FEED) && vec_valid_i;
  assign is_last   = (count == (k_len - KW'(1)));
  assign start_job = (state == IDLE) && start_i && (k_len_i != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_job) state_nxt = FEED;
      FEED:    if (accept && is_last) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign vec_ready_o = (state == FEED);
  assign busy_o      = (state != IDLE);
  assign done_o      = zero_done || ((state == FLUSH) && (flush_cnt == FLUSH_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_len     <= '0;
      count     <= '0;
      flush_cnt <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      // A zero-length job never leaves IDLE but still owes its caller a done pulse.
      zero_done <= (state == IDLE) && start_i && (k_len_i == '0);
      if (start_job) begin
        k_len <= k_len_i;
        count <= '0;
      end else if (accept) begin
        count <= count + KW'(1);
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else                flush_cnt <= '0;
    end
  end

  // Non-accepting cycles still inject an all-zero slot so bubbles skew like data.
  always_comb begin
    for (int l = 0; l < N; l++) begin
      in_slot[l]       = '0;
      in_slot[l].valid = accept;
      in_slot[l].last  = accept && is_last;
      if (accept) in_slot[l].data = vec_data_i[l*DW +: DW];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    slot_t line [0:i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) line[j] <= '0;
      end else begin
        line[0] <= in_slot[i];
        for (int j = 1; j <= i; j++) line[j] <= line[j-1];
      end
    end

    assign lane_valid_o[i]                = line[i].valid;
    assign lane_data_o[i*(DW+1) +: DW+1]  = {line[i].data, line[i].last};
  end

endmodule

// File: tb/tb_sa_edge_feeder.sv
// Self-checking bench for sa_edge_feeder: a hand-derived vector table, directed corner
// sequences and randomized traffic compared against a cycle-indexed job model.
`timescale 1ns/1ps
module tb_sa_edge_feeder;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int KW = 8;
  localparam int LW = N*(DW+1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [KW-1:0]   k_len_i;
  logic            vec_valid_i;
  logic            vec_ready_o;
  logic [N*DW-1:0] vec_data_i;
  logic [LW-1:0]   lane_data_o;
  logic [N-1:0]    lane_valid_o;
  logic            busy_o;
  logic            done_o;

  sa_edge_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
    .vec_valid_i(vec_valid_i), .vec_ready_o(vec_ready_o), .vec_data_i(vec_data_i),
    .lane_data_o(lane_data_o), .lane_valid_o(lane_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per-cycle record of what entered the feeder, {valid, last, vector}.
  int                 cyc = 0;
  logic [N*DW+1:0]    hist [int];
  bit                 m_busy, m_feeding;
  int                 m_k, m_cnt, m_done_at, m_idle_at, m_last_accept;

  int tal_valid [N];
  int tal_last [N];
  int tal_last_idx [N];
  int done_cyc;

  typedef struct {
    bit              s;
    int              k;
    bit              vv;
    logic [N*DW-1:0] d;
    bit              e_ready, e_busy, e_done;
    logic [N-1:0]    e_lv;
    logic [LW-1:0]   e_ld;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(bit s, int k, bit vv, logic [N*DW-1:0] d, bit r, bit b,
                              bit dn, logic [N-1:0] lv, logic [LW-1:0] ld);
    vec_t v;
    v.s = s; v.k = k; v.vv = vv; v.d = d;
    v.e_ready = r; v.e_busy = b; v.e_done = dn; v.e_lv = lv; v.e_ld = ld;
    return v;
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(bit s, int k, bit vv, logic [N*DW-1:0] d);
    start_i     = s;
    k_len_i     = KW'(k);
    vec_valid_i = vv;
    vec_data_i  = d;
  endtask

  task automatic model_reset();
    m_busy = 0; m_feeding = 0; m_k = 0; m_cnt = 0;
    m_done_at = -1; m_idle_at = -1;
    hist.delete();
  endtask

  task automatic clear_tallies();
    for (int i = 0; i < N; i++) begin
      tal_valid[i] = 0; tal_last[i] = 0; tal_last_idx[i] = -1;
    end
    done_cyc = -1;
  endtask

  // Called at the falling edge: compare against the model, tally, then advance the model.
  task automatic model_check_update();
    logic [N-1:0]    ev;
    logic [LW-1:0]   ed;
    logic [N*DW+1:0] e;
    logic [N*DW+1:0] entry;
    ev = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      if (hist.exists(cyc-1-i)) begin
        e = hist[cyc-1-i];
        ev[i] = e[N*DW+1];
        ed[i*(DW+1) +: DW+1] = {e[i*DW +: DW], e[N*DW]};
      end
    end
    check_output("vec_ready", vec_ready_o, m_feeding);
    check_output("busy", busy_o, m_busy);
    check_output("done", done_o, (cyc == m_done_at));
    check_output("lane_valid", lane_valid_o, ev);
    check_output("lane_data", lane_data_o, ed);

    for (int i = 0; i < N; i++) begin
      if (lane_valid_o[i]) begin
        tal_valid[i]++;
        if (lane_data_o[i*(DW+1)]) begin
          tal_last[i]++;
          tal_last_idx[i] = tal_valid[i];
        end
      end
    end
    if (done_o) done_cyc = cyc;

    entry = '0;
    if (!m_busy && start_i) begin
      if (k_len_i == '0) m_done_at = cyc + 1;
      else begin
        m_busy = 1; m_feeding = 1; m_k = int'(k_len_i); m_cnt = 0;
      end
    end else if (m_feeding && vec_valid_i) begin
      entry[N*DW+1]    = 1'b1;
      entry[N*DW]      = (m_cnt == m_k - 1);
      entry[N*DW-1:0]  = vec_data_i;
      if (m_cnt == m_k - 1) begin
        m_feeding = 0;
        m_done_at = cyc + N;
        m_idle_at = cyc + N + 1;
        m_last_accept = cyc;
      end
      m_cnt++;
    end
    if (m_busy && !m_feeding && (cyc + 1 == m_idle_at)) m_busy = 0;
    hist[cyc] = entry;
  endtask

  task automatic step();
    @(negedge clk);
    model_check_update();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_all_zero(string name);
    check_output({name, "_ready"}, vec_ready_o, 0);
    check_output({name, "_busy"}, busy_o, 0);
    check_output({name, "_done"}, done_o, 0);
    check_output({name, "_lane_valid"}, lane_valid_o, 0);
    check_output({name, "_lane_data"}, lane_data_o, 0);
  endtask

  initial begin
    int c0;

    // Reset held with random inputs.
    rst_n = 1'b0;
    apply_stimulus(1'b1, 3, 1'b1, N*DW'($urandom));
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check_all_zero("reset_hold");
      @(posedge clk); #1;
      cyc++;
      apply_stimulus($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                     N*DW'($urandom));
    end
    rst_n = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 0, '0);
    step();

    // Hand-derived table for K=3, vectors accepted in table cycles 1..3.
    tbl[0] = mk(1, 3, 0, 16'h0000, 0, 0, 0, 2'b00, 18'h00000);
    tbl[1] = mk(0, 0, 1, 16'h0201, 1, 1, 0, 2'b00, 18'h00000);
    tbl[2] = mk(0, 0, 1, 16'h0403, 1, 1, 0, 2'b01, 18'h00002);
    tbl[3] = mk(0, 0, 1, 16'h0605, 1, 1, 0, 2'b11, 18'h00806);
    tbl[4] = mk(0, 0, 0, 16'h0000, 0, 1, 0, 2'b11, 18'h0100B);
    tbl[5] = mk(0, 0, 0, 16'h0000, 0, 1, 1, 2'b10, 18'h01A00);
    tbl[6] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 2'b00, 18'h00000);
    for (int t = 0; t < 7; t++) begin
      apply_stimulus(tbl[t].s, tbl[t].k, tbl[t].vv, tbl[t].d);
      @(negedge clk);
      check_output("tbl_ready", vec_ready_o, tbl[t].e_ready);
      check_output("tbl_busy", busy_o, tbl[t].e_busy);
      check_output("tbl_done", done_o, tbl[t].e_done);
      check_output("tbl_lane_valid", lane_valid_o, tbl[t].e_lv);
      check_output("tbl_lane_data", lane_data_o, tbl[t].e_ld);
      model_check_update();
      @(posedge clk); #1;
      cyc++;
    end

    // Bubble in the second FEED cycle: done slips from cycle 5 to cycle 6.
    clear_tallies();
    c0 = cyc;
    apply_stimulus(1, 3, 0, '0);        step();
    apply_stimulus(0, 0, 1, 16'h0201); step();
    apply_stimulus(0, 0, 0, 16'hAAAA); step();
    apply_stimulus(0, 0, 1, 16'h0403); step();
    apply_stimulus(0, 0, 1, 16'h0605); step();
    apply_stimulus(0, 0, 0, '0);
    for (int r = 0; r < 4; r++) step();
    check_output("bubble_done_cycle", done_cyc - c0, 6);
    check_output("bubble_lane1_count", tal_valid[1], 3);

    // K=0: done the following cycle, no lane traffic, never busy.
    clear_tallies();
    c0 = cyc;
    apply_stimulus(1, 0, 1, 16'h1234); step();
    apply_stimulus(0, 0, 1, 16'h5678);
    for (int r = 0; r < 4; r++) step();
    check_output("k0_done_cycle", done_cyc - c0, 1);
    check_output("k0_lane0_valid", tal_valid[0], 0);

    // start_i with k_len=7 during FEED must not alter the K=3 job.
    clear_tallies();
    apply_stimulus(1, 3, 0, '0); step();
    apply_stimulus(0, 0, 1, 16'h1111); step();
    apply_stimulus(1, 7, 1, 16'h2222); step();
    apply_stimulus(0, 0, 1, 16'h3333); step();
    apply_stimulus(0, 0, 1, 16'h4444);
    for (int r = 0; r < 8; r++) step();
    check_output("restart_lane0_count", tal_valid[0], 3);
    check_output("restart_lane1_last_idx", tal_last_idx[1], 3);

    // Asynchronous reset in the middle of a job clears outputs immediately.
    apply_stimulus(1, 5, 0, '0); step();
    apply_stimulus(0, 0, 1, 16'h0A0B); step();
    apply_stimulus(0, 0, 1, 16'h0C0D); step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    apply_stimulus(0, 0, 0, '0);
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    clear_tallies();
    for (int r = 0; r < 6; r++) step();
    check_output("post_reset_no_done", done_cyc, -1);

    // Randomized traffic against the model.
    for (int r = 0; r < 600; r++) begin
      apply_stimulus(($urandom % 8) == 0, $urandom_range(0, 5), ($urandom % 4) != 0,
                     N*DW'($urandom));
      step();
    end
    apply_stimulus(0, 0, 0, '0);
    for (int r = 0; r < 10; r++) step();

    // K=255 with continuous vectors.
    clear_tallies();
    apply_stimulus(1, 255, 0, '0); step();
    for (int r = 0; r < 262; r++) begin
      apply_stimulus(0, 0, 1, N*DW'($urandom));
      step();
    end
    apply_stimulus(0, 0, 0, '0);
    for (int r = 0; r < 4; r++) step();
    for (int i = 0; i < N; i++) begin
      check_output("k255_valid_count", tal_valid[i], 255);
      check_output("k255_last_count", tal_last[i], 1);
      check_output("k255_last_idx", tal_last_idx[i], 255);
    end
    check_output("k255_done_latency", done_cyc - m_last_accept, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
